fig_09_cache_flush: RTL and testbench
=====================================

FIG_09_CACHE_FLUSH -- requirements
Module: fig_09_cache_flush

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port flush, input, 1 bit: single-cycle request to write the pixel cache row back to RAM.
REQ-004 SHALL have port bpr, input, 8 bits: bit-pending mask from the bit-plane slices; bit 7 is leftmost pixel.
REQ-005 SHALL have port dump, input, 64 bits: cache plane data; plane p occupies bits [8p+7:8p].
REQ-006 SHALL have port bpp_mode, input, 2 bits: 00=2 planes, 01=4 planes, 1x=8 planes.
REQ-007 SHALL have port base_addr, input, 17 bits: RAM byte address of plane 0 for this row.
REQ-008 SHALL have ports ram_req, ram_we, ram_addr[16:0], ram_wdata[7:0], all outputs: RAM bus request, write strobe, address and write data.
REQ-009 SHALL have ports ram_ack, input, 1 bit, and ram_rdata, input, 8 bits: transfer complete and read data, valid in the ack cycle.
REQ-010 SHALL have ports busy, output, 1 bit, and done, output, 1 bit: flush in progress; one-cycle completion pulse.
REQ-011 SHALL have port clr_bpr, output, 1 bit: one-cycle pulse, coincident with done, clearing the slices' pending bits.

Function
REQ-012 SHALL use states IDLE, RD, WR, NEXT, FIN.
REQ-013 SHALL in IDLE sample flush; on flush=1, latch bpr, dump, bpp_mode and base_addr, set plane counter to 0, and assert busy from the next cycle.
REQ-014 SHALL, when latched bpr=8'h00, go IDLE->FIN with no RAM access; done follows flush by 2 cycles.
REQ-015 SHALL otherwise enter RD for plane 0; ram_req rises in the first cycle after flush.
REQ-016 SHALL compute plane address as base_addr + 16*(p>>1) + (p&1), modulo 2^17 (wrap, no carry out).
REQ-017 SHALL in RD drive ram_req=1, ram_we=0 and a stable ram_addr until ram_ack=1; it SHALL capture ram_rdata in the ack cycle and then enter WR.
REQ-018 SHALL in WR drive ram_req=1, ram_we=1, ram_wdata=(dump_p & bpr) | (rdata & ~bpr), with addr, we and data stable until ram_ack=1, then enter NEXT.
REQ-019 SHALL ensure ram_req is low for exactly one cycle (NEXT) between consecutive transfers.
REQ-020 SHALL in NEXT increment p; at the last plane (1, 3 or 7 per bpp_mode) go to FIN, else go to RD (or WR per REQ-027).
REQ-021 SHALL in FIN pulse done=1 and clr_bpr=1 for one cycle, drop busy, and return to IDLE.
REQ-022 SHALL ignore flush while busy=1 or in FIN; no queuing.
REQ-023 SHALL ignore ram_ack when ram_req=0.
REQ-024 SHALL hold ram_wdata at 0 outside WR and ram_addr at its last value when idle.

Reset
REQ-025 SHALL, on reset=1 at any time including mid-transfer, immediately force IDLE, p=0, and ram_req, ram_we, busy, done, clr_bpr to 0, and ram_addr, ram_wdata and latched registers to 0.
REQ-026 SHALL resume flush sampling on the first clk edge after reset falls.

Configuration
REQ-027 SHALL, when FLUSH_SKIP_READ_EN is defined and latched bpr=8'hFF, skip RD for every plane (write dump_p directly, 1 transfer per plane); without the macro it SHALL always do the read-modify-write (2 transfers per plane).

Verification
REQ-028 SHALL check bpr=00, flush: no ram_req; done and clr_bpr pulse 2 cycles after flush.
REQ-029 SHALL check 2bpp, base=0x00100, bpr=F0, dump plane0=AA, plane1=55, rdata=0F always, 1-cycle ack: writes 0x00100<-AF, 0x00101<-5F, with a read preceding each.
REQ-030 SHALL check 8bpp, base=0x1FFF0, bpr=FF, with FLUSH_SKIP_READ_EN: 8 writes only, addresses 1FFF0,1FFF1,00000,00001,00010,00011,00020,00021 (wrap); without the macro: 16 transfers.
REQ-031 SHALL check 4bpp with ram_ack delayed 3 cycles per transfer: addr, we and data stable throughout the wait; second flush pulsed mid-operation is ignored; exactly one done.
REQ-032 SHALL check reset asserted during the WR of plane 2 (4bpp): ram_req drops asynchronously; no done; a new flush afterwards runs from plane 0.

Source files
------------

// File: rtl/fig_09_cache_flush_if.sv
// RAM bus between the cache-flush engine (master) and the frame-buffer RAM port (slave).
// Request, write strobe, address and write data stay valid until ram_ack; read data is valid in the ack cycle.
interface fig_09_cache_flush_if;
  logic        ram_req;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_ack;
  logic [7:0]  ram_rdata;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_ack, ram_rdata
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_ack, ram_rdata
  );
endinterface

// File: rtl/fig_09_cache_flush.sv
// Pixel-cache row write-back: read-modify-write of each bit plane under the pending mask.
// Optional macro FLUSH_SKIP_READ_EN: when every pixel is pending, planes are written without the read.
module fig_09_cache_flush (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [7:0]                 bpr,
  input  logic [63:0]                dump,
  input  logic [1:0]                 bpp_mode,
  input  logic [16:0]                base_addr,
  fig_09_cache_flush_if.master       ram,
  output logic                       busy,
  output logic                       done,
  output logic                       clr_bpr
);

  typedef enum logic [2:0] {IDLE, RD, WR, NEXT, FIN} state_t;

  state_t      state_reg;
  logic [2:0]  p_reg;
  logic [7:0]  bpr_reg;
  logic [63:0] dump_reg;
  logic [1:0]  bpp_reg;
  logic [16:0] base_reg;
  logic        req_reg;
  logic        we_reg;
  logic [16:0] addr_reg;
  logic [7:0]  wdata_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        clr_reg;
  logic        skip_now;
  logic        skip_lat;
  logic [2:0]  p_next;

`ifdef FLUSH_SKIP_READ_EN
  assign skip_now = (bpr == 8'hFF);
  assign skip_lat = (bpr_reg == 8'hFF);
`else
  assign skip_now = 1'b0;
  assign skip_lat = 1'b0;
`endif

  assign p_next = p_reg + 3'd1;

  // Plane pairs share a 16-byte stride; odd planes sit one byte above their even partner.
  function automatic logic [16:0] plane_addr(input logic [16:0] base, input logic [2:0] p);
    return base + {11'd0, p[2:1], 4'd0} + {16'd0, p[0]};
  endfunction

  function automatic logic [7:0] plane_byte(input logic [63:0] d, input logic [2:0] p);
    return d[{p, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] merge(input logic [7:0] d, input logic [7:0] r, input logic [7:0] m);
    return (d & m) | (r & ~m);
  endfunction

  function automatic logic [2:0] last_plane(input logic [1:0] mode);
    return mode[1] ? 3'd7 : (mode[0] ? 3'd3 : 3'd1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      p_reg     <= 3'd0;
      bpr_reg   <= 8'd0;
      dump_reg  <= 64'd0;
      bpp_reg   <= 2'd0;
      base_reg  <= 17'd0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= 17'd0;
      wdata_reg <= 8'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      clr_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      clr_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (flush) begin
            bpr_reg  <= bpr;
            dump_reg <= dump;
            bpp_reg  <= bpp_mode;
            base_reg <= base_addr;
            p_reg    <= 3'd0;
            busy_reg <= 1'b1;
            if (bpr == 8'h00) begin
              state_reg <= FIN;
            end else begin
              req_reg  <= 1'b1;
              addr_reg <= plane_addr(base_addr, 3'd0);
              if (skip_now) begin
                state_reg <= WR;
                we_reg    <= 1'b1;
                wdata_reg <= merge(dump[7:0], 8'h00, bpr);
              end else begin
                state_reg <= RD;
              end
            end
          end
        end
        RD: begin
          if (ram.ram_ack) begin
            state_reg <= WR;
            we_reg    <= 1'b1;
            wdata_reg <= merge(plane_byte(dump_reg, p_reg), ram.ram_rdata, bpr_reg);
          end
        end
        WR: begin
          if (ram.ram_ack) begin
            state_reg <= NEXT;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            wdata_reg <= 8'd0;
          end
        end
        NEXT: begin
          p_reg <= p_next;
          if (p_reg == last_plane(bpp_reg)) begin
            state_reg <= FIN;
          end else begin
            req_reg  <= 1'b1;
            addr_reg <= plane_addr(base_reg, p_next);
            if (skip_lat) begin
              state_reg <= WR;
              we_reg    <= 1'b1;
              wdata_reg <= merge(plane_byte(dump_reg, p_next), 8'h00, bpr_reg);
            end else begin
              state_reg <= RD;
            end
          end
        end
        FIN: begin
          done_reg  <= 1'b1;
          clr_reg   <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ram.ram_req   = req_reg;
  assign ram.ram_we    = we_reg;
  assign ram.ram_addr  = addr_reg;
  assign ram.ram_wdata = wdata_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign clr_bpr       = clr_reg;

endmodule

// File: tb/tb_fig_09_cache_flush.sv
// Directed bench for fig_09_cache_flush: a RAM slave with programmable ack delay logs every transfer,
// and directed flush scenarios compare the log, done timing and reset behaviour against hand-computed values.
module tb_fig_09_cache_flush;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  bpr = 8'h00;
  logic [63:0] dump = 64'd0;
  logic [1:0]  bpp_mode = 2'b00;
  logic [16:0] base_addr = 17'd0;
  logic        busy, done, clr_bpr;

  fig_09_cache_flush_if ram_bus ();

  fig_09_cache_flush dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bpr       (bpr),
    .dump      (dump),
    .bpp_mode  (bpp_mode),
    .base_addr (base_addr),
    .ram       (ram_bus.master),
    .busy      (busy),
    .done      (done),
    .clr_bpr   (clr_bpr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [16:0] addr;
    logic [7:0]  wdata;
    int          start;
    int          gap;
  } xfer_t;

  xfer_t log_q[$];
  xfer_t cur;
  int    assert_cnt = 0;
  int    fail_cnt = 0;
  int    cyc = 0;
  int    flush_cyc = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    ack_delay = 0;
  int    wait_cnt = 0;
  int    last_stop = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM slave: acks after ack_delay wait cycles and records each completed transfer.
  always @(negedge clk) begin
    if (reset) begin
      ram_bus.ram_ack = 1'b0;
      wait_cnt = 0;
    end else if (ram_bus.ram_req) begin
      if (wait_cnt == 0) begin
        cur.we    = ram_bus.ram_we;
        cur.addr  = ram_bus.ram_addr;
        cur.wdata = ram_bus.ram_wdata;
        cur.start = cyc;
        cur.gap   = cyc - last_stop - 1;
      end else begin
        check_val("stable_we", ram_bus.ram_we, cur.we);
        check_val("stable_addr", ram_bus.ram_addr, cur.addr);
        check_val("stable_wdata", ram_bus.ram_wdata, cur.wdata);
      end
      if (wait_cnt == ack_delay) begin
        ram_bus.ram_ack = 1'b1;
        last_stop = cyc;
        log_q.push_back(cur);
        $display("xfer cyc=%0d we=%0b addr=%05h wdata=%02h gap=%0d",
                 cur.start, cur.we, cur.addr, cur.wdata, cur.gap);
        wait_cnt = 0;
      end else begin
        ram_bus.ram_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      ram_bus.ram_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (done || clr_bpr) check_val("clr_with_done", clr_bpr, done);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic pulse_flush(input logic [7:0] b, input logic [63:0] d, input logic [1:0] m,
                             input logic [16:0] a);
    @(negedge clk);
    bpr = b; dump = d; bpp_mode = m; base_addr = a;
    flush = 1'b1;
    flush_cyc = cyc;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget && done_cnt == start; i++) @(posedge clk);
    check_val("done_seen", (done_cnt != start), 1'b1);
  endtask

  task automatic expect_xfer(input string tag, input logic we, input logic [16:0] a,
                             input logic [7:0] wd, input int gap);
    xfer_t x;
    if (log_q.size() == 0) begin
      check_val({tag, "_present"}, 1'b0, 1'b1);
      return;
    end
    x = log_q.pop_front();
    check_val({tag, "_we"}, x.we, we);
    check_val({tag, "_addr"}, x.addr, a);
    check_val({tag, "_wdata"}, x.wdata, wd);
    if (gap >= 0) check_val({tag, "_gap"}, x.gap, gap);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_req"}, ram_bus.ram_req, 1'b0);
    check_val({tag, "_we"}, ram_bus.ram_we, 1'b0);
    check_val({tag, "_addr"}, ram_bus.ram_addr, 17'd0);
    check_val({tag, "_wdata"}, ram_bus.ram_wdata, 8'd0);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_done"}, done, 1'b0);
    check_val({tag, "_clr"}, clr_bpr, 1'b0);
  endtask

  logic [16:0] wrap_addr [8];
  logic [16:0] a4 [4];

  initial begin
    int d0;
    logic hit;
    wrap_addr = '{17'h1FFF0, 17'h1FFF1, 17'h00000, 17'h00001,
                  17'h00010, 17'h00011, 17'h00020, 17'h00021};
    ram_bus.ram_ack   = 1'b0;
    ram_bus.ram_rdata = 8'h0F;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Nothing pending: no RAM traffic, done two cycles after flush
    d0 = done_cnt;
    pulse_flush(8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 17'h01234);
    wait_done(20);
    repeat (5) @(negedge clk);
    check_val("empty_done_lat", done_cyc - flush_cyc, 2);
    check_val("empty_done_cnt", done_cnt - d0, 1);
    check_val("empty_no_xfer", log_q.size(), 0);
    check_val("empty_busy_after", busy, 1'b0);

    // 2bpp read-modify-write, 1-cycle ack
    ack_delay = 0;
    ram_bus.ram_rdata = 8'h0F;
    pulse_flush(8'hF0, 64'h0000_0000_0000_55AA, 2'b00, 17'h00100);
    check_val("2bpp_busy", busy, 1'b1);
    wait_done(50);
    check_val("2bpp_done_lat", done_cyc - flush_cyc, 8);
    check_val("2bpp_first_req", log_q.size() > 0 ? log_q[0].start - flush_cyc : -1, 1);
    expect_xfer("2bpp_r0", 1'b0, 17'h00100, 8'h00, -1);
    expect_xfer("2bpp_w0", 1'b1, 17'h00100, 8'hAF, 0);
    expect_xfer("2bpp_r1", 1'b0, 17'h00101, 8'h00, 1);
    expect_xfer("2bpp_w1", 1'b1, 17'h00101, 8'h5F, 0);
    check_val("2bpp_extra", log_q.size(), 0);
    @(negedge clk);
    check_val("2bpp_idle_wdata", ram_bus.ram_wdata, 8'h00);
    check_val("2bpp_hold_addr", ram_bus.ram_addr, 17'h00101);

    // 8bpp all pending, address wraps at 2^17
    pulse_flush(8'hFF, 64'h1716_1514_1312_1110, 2'b10, 17'h1FFF0);
    wait_done(200);
    for (int p = 0; p < 8; p++) begin
`ifdef FLUSH_SKIP_READ_EN
      expect_xfer("8bpp_w", 1'b1, wrap_addr[p], 8'(8'h10 + p), (p == 0) ? -1 : 1);
`else
      expect_xfer("8bpp_r", 1'b0, wrap_addr[p], 8'h00, (p == 0) ? -1 : 1);
      expect_xfer("8bpp_w", 1'b1, wrap_addr[p], 8'(8'h10 + p), 0);
`endif
    end
    check_val("8bpp_extra", log_q.size(), 0);

    // 4bpp with 3 wait cycles per transfer and an ignored second flush
    ack_delay = 3;
    ram_bus.ram_rdata = 8'hC3;
    a4 = '{17'h00200, 17'h00201, 17'h00210, 17'h00211};
    d0 = done_cnt;
    pulse_flush(8'h3C, 64'h0000_0000_4433_2211, 2'b01, 17'h00200);
    repeat (10) @(negedge clk);
    check_val("4bpp_busy_mid", busy, 1'b1);
    pulse_flush(8'h00, 64'h0, 2'b00, 17'h0ABCD);
    wait_done(300);
    repeat (30) @(negedge clk);
    check_val("4bpp_one_done", done_cnt - d0, 1);
    for (int p = 0; p < 4; p++) begin
      expect_xfer("4bpp_r", 1'b0, a4[p], 8'h00, (p == 0) ? -1 : 1);
      expect_xfer("4bpp_w", 1'b1, a4[p], (p == 0) ? 8'hD3 : (p == 1) ? 8'hE3 : (p == 2) ? 8'hF3 : 8'hC7, 0);
    end
    check_val("4bpp_extra", log_q.size(), 0);

    // Reset during the write of plane 2
    ack_delay = 0;
    ram_bus.ram_rdata = 8'hF0;
    d0 = done_cnt;
    pulse_flush(8'h0F, 64'h0000_0000_8483_8281, 2'b01, 17'h00300);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (ram_bus.ram_req && ram_bus.ram_we && ram_bus.ram_addr == 17'h00310) hit = 1'b1;
    end
    check_val("rst_wr2_found", hit, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_val("rst_async_req", ram_bus.ram_req, 1'b0);
    @(negedge clk);
    check_idle_outputs("rst_mid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_val("rst_no_done", done_cnt - d0, 0);
    check_val("rst_partial_log", log_q.size(), 5);
    log_q.delete();
    a4 = '{17'h00400, 17'h00401, 17'h00410, 17'h00411};
    pulse_flush(8'h0F, 64'h0000_0000_8483_8281, 2'b01, 17'h00400);
    wait_done(100);
    for (int p = 0; p < 4; p++) begin
      expect_xfer("post_r", 1'b0, a4[p], 8'h00, (p == 0) ? -1 : 1);
      expect_xfer("post_w", 1'b1, a4[p], 8'(8'hF1 + p), 0);
    end
    check_val("post_extra", log_q.size(), 0);
    check_val("post_one_done", done_cnt - d0, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
